// File: rtl/ccu2d_accum.sv
// ccu2d_accum -- registered accumulator/counter behind a CCU2D-style carry chain.
//
// The arithmetic is modelled as WIDTH/2 two-bit slices. Each slice forms the
// propagate term the way an INIT-programmed CCU2D half does (INJECT1 = "NO"),
// and the ripple result is captured in flip-flops together with carry,
// signed-overflow and zero flags.
//
// Ports:
//   CK   in   1      clock, rising edge
//   CD   in   1      asynchronous clear, active-high
//   SP   in   1      clock enable; an operation is accepted only when SP=1
//   OP   in   2      00 hold, 01 add, 10 subtract, 11 load
//   CIN  in   1      carry into slice 0 (ignored for load)
//   B    in   WIDTH  operand
//   Q    out  WIDTH  accumulator register
//   CO   out  1      registered carry out of the last slice (1 = no borrow on subtract)
//   OV   out  1      registered signed-overflow flag
//   Z    out  1      registered flag, 1 when Q is all zeros
//   VLD  out  1      one-cycle strobe after each accepted operation
//
// Handshake: VLD is a valid-only strobe. There is no ready; every edge with
// SP=1 and CD=0 accepts the operation on OP/B/CIN, and VLD is high for exactly
// the following cycle. Back-to-back operations are allowed on every cycle.
module ccu2d_accum #(
  parameter int WIDTH = 16
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             SP,
  input  logic [1:0]       OP,
  input  logic             CIN,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OV,
  output logic             Z,
  output logic             VLD
);

  if ((WIDTH % 2) != 0 || WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "ccu2d_accum: WIDTH=%0d must be even and within 2..64", WIDTH);
  end

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic [WIDTH-1:0] b_eff;  // operand after add/subtract selection
  logic [WIDTH-1:0] prop;   // per-bit propagate
  logic [WIDTH-1:0] s;      // chain sum bits
  logic [WIDTH:0]   c;      // c[i] is the carry into bit i; c[WIDTH] is the final COUT
  logic             ov;

  // Ripple chain: outer loop walks the slices, inner loop the two bits of a
  // slice. The carry into slice k is simply the carry out of its upper bit of
  // slice k-1, so the flat c[] vector is the slice-to-slice COUT/CIN wiring.
  always_comb begin
    b_eff = (OP == OP_SUB) ? ~B : B;
    prop  = '0;
    s     = '0;
    c     = '0;
    c[0]  = CIN;
    for (int k = 0; k < WIDTH / 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        prop[2*k+j] = Q[2*k+j] ^ b_eff[2*k+j];
        s[2*k+j]    = prop[2*k+j] ^ c[2*k+j];
        // When the bit does not propagate, Q and b' are equal, so Q is the generate term.
        c[2*k+j+1]  = prop[2*k+j] ? c[2*k+j] : Q[2*k+j];
      end
    end
    // Overflow: both inputs share a sign and the result sign differs from it.
    ov = (Q[WIDTH-1] == b_eff[WIDTH-1]) && (s[WIDTH-1] != Q[WIDTH-1]);
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      Q   <= '0;
      CO  <= 1'b0;
      OV  <= 1'b0;
      Z   <= 1'b1;
      VLD <= 1'b0;
    end else begin
      VLD <= SP;
      if (SP) begin
        case (OP)
          OP_HOLD: ;
          OP_ADD, OP_SUB: begin
            Q  <= s;
            CO <= c[WIDTH];
            OV <= ov;
            Z  <= (s == '0);
          end
          OP_LOAD: begin
            Q  <= B;
            CO <= 1'b0;
            OV <= 1'b0;
            Z  <= (B == '0);
          end
          // Only reachable with an unknown OP: poison the state rather than
          // silently picking an operation.
          default: begin
            Q  <= 'x;
            CO <= 1'bx;
            OV <= 1'bx;
            Z  <= 1'bx;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ccu2d_accum.sv
// Bench for ccu2d_accum. Four instances (WIDTH 8, 2, 16, 64) share one
// stimulus stream; each is compared against an arithmetic reference model
// built from plain (WIDTH+1)-bit sums.
module tb_ccu2d_accum;

  localparam int N_DUT = 4;

  logic        CK;
  logic        CD;
  logic        SP;
  logic [1:0]  OP;
  logic        CIN;
  logic [63:0] b;

  logic [7:0]  q8;
  logic [1:0]  q2;
  logic [15:0] q16;
  logic [63:0] q64;
  logic [N_DUT-1:0] co_v, ov_v, z_v, vld_v;

  ccu2d_accum #(.WIDTH(8)) u_w8 (
    .CK(CK), .CD(CD), .SP(SP), .OP(OP), .CIN(CIN), .B(b[7:0]),
    .Q(q8), .CO(co_v[0]), .OV(ov_v[0]), .Z(z_v[0]), .VLD(vld_v[0]));
  ccu2d_accum #(.WIDTH(2)) u_w2 (
    .CK(CK), .CD(CD), .SP(SP), .OP(OP), .CIN(CIN), .B(b[1:0]),
    .Q(q2), .CO(co_v[1]), .OV(ov_v[1]), .Z(z_v[1]), .VLD(vld_v[1]));
  ccu2d_accum #(.WIDTH(16)) u_w16 (
    .CK(CK), .CD(CD), .SP(SP), .OP(OP), .CIN(CIN), .B(b[15:0]),
    .Q(q16), .CO(co_v[2]), .OV(ov_v[2]), .Z(z_v[2]), .VLD(vld_v[2]));
  ccu2d_accum #(.WIDTH(64)) u_w64 (
    .CK(CK), .CD(CD), .SP(SP), .OP(OP), .CIN(CIN), .B(b),
    .Q(q64), .CO(co_v[3]), .OV(ov_v[3]), .Z(z_v[3]), .VLD(vld_v[3]));

  logic [63:0] dq [N_DUT];
  assign dq[0] = {56'd0, q8};
  assign dq[1] = {62'd0, q2};
  assign dq[2] = {48'd0, q16};
  assign dq[3] = q64;

  // ---------------- clock ----------------
  initial CK = 1'b0;
  always #5 CK = ~CK;

  // ---------------- reference model ----------------
  int          wid [N_DUT] = '{8, 2, 16, 64};
  logic [63:0] m_q [N_DUT];
  logic        m_co [N_DUT];
  logic        m_ov [N_DUT];
  logic        m_z [N_DUT];
  logic        m_vld [N_DUT];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_DUT; i++) begin
      m_q[i] = '0; m_co[i] = 1'b0; m_ov[i] = 1'b0; m_z[i] = 1'b1; m_vld[i] = 1'b0;
    end
  endtask

  // Applies one clock edge's worth of behaviour: add/subtract are plain
  // (w+1)-bit sums, subtract uses the ones' complement operand.
  task automatic model_step(input logic [1:0] op, input logic [63:0] bv,
                            input logic cin, input logic sp);
    logic [63:0] mk, bo, sum;
    logic [64:0] full;
    int w;
    for (int i = 0; i < N_DUT; i++) begin
      w  = wid[i];
      mk = mask_of(w);
      m_vld[i] = sp;
      if (sp) begin
        if (op == 2'b01 || op == 2'b10) begin
          bo   = (op == 2'b10) ? (~bv & mk) : (bv & mk);
          full = {1'b0, m_q[i]} + {1'b0, bo} + {64'd0, cin};
          sum  = full[63:0] & mk;
          m_co[i] = full[w];
          m_ov[i] = (m_q[i][w-1] == bo[w-1]) && (sum[w-1] != m_q[i][w-1]);
          m_q[i]  = sum;
          m_z[i]  = (sum == 64'd0);
        end else if (op == 2'b11) begin
          m_q[i]  = bv & mk;
          m_co[i] = 1'b0;
          m_ov[i] = 1'b0;
          m_z[i]  = (m_q[i] == 64'd0);
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int w, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s w=%0d observed=%h expected=%h", tag, w, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N_DUT; i++) begin
      chk({tag, "_q"},   wid[i], dq[i],            m_q[i]);
      chk({tag, "_co"},  wid[i], {63'd0, co_v[i]},  {63'd0, m_co[i]});
      chk({tag, "_ov"},  wid[i], {63'd0, ov_v[i]},  {63'd0, m_ov[i]});
      chk({tag, "_z"},   wid[i], {63'd0, z_v[i]},   {63'd0, m_z[i]});
      chk({tag, "_vld"}, wid[i], {63'd0, vld_v[i]}, {63'd0, m_vld[i]});
    end
  endtask

  // Directed check on the WIDTH=8 instance against hand-derived constants.
  task automatic chk8(input string tag, input logic [7:0] q, input logic co,
                      input logic ov, input logic z, input logic vld);
    chk({tag, "_q8"},   8, dq[0],                {56'd0, q});
    chk({tag, "_co8"},  8, {63'd0, co_v[0]},     {63'd0, co});
    chk({tag, "_ov8"},  8, {63'd0, ov_v[0]},     {63'd0, ov});
    chk({tag, "_z8"},   8, {63'd0, z_v[0]},      {63'd0, z});
    chk({tag, "_vld8"}, 8, {63'd0, vld_v[0]},    {63'd0, vld});
  endtask

  // ---------------- driver ----------------
  // Called away from the rising edge; drives inputs, takes one edge, samples #1 later.
  task automatic do_op(input logic [1:0] op, input logic [63:0] bv,
                       input logic cin, input logic sp);
    OP = op; b = bv; CIN = cin; SP = sp;
    @(posedge CK);
    model_step(op, bv, cin, sp);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    CD = 1'b1; SP = 1'b0; OP = 2'b00; CIN = 1'b0; b = '0;
    model_reset();
    repeat (2) @(posedge CK);
    #1;
    check_all("reset");
    CD = 1'b0;

    // All-ones + 1 wraps to zero with carry out.
    do_op(2'b11, 64'hFF, 1'b0, 1'b1);
    check_all("ld_ff");
    do_op(2'b01, 64'h01, 1'b0, 1'b1);
    chk8("wrap_add", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    check_all("wrap_add");
    do_op(2'b00, 64'h0, 1'b0, 1'b0);
    chk8("vld_drop", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // 0x80 - 1 overflows into 0x7F, no borrow.
    do_op(2'b11, 64'h80, 1'b0, 1'b1);
    do_op(2'b10, 64'h01, 1'b1, 1'b1);
    chk8("sub_ov", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
    check_all("sub_ov");

    // 0 - 1 wraps to all-ones with borrow.
    do_op(2'b11, 64'h00, 1'b0, 1'b1);
    chk8("ld_zero", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    do_op(2'b10, 64'h01, 1'b1, 1'b1);
    chk8("sub_borrow", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("sub_borrow");

    // Counter mode with one SP=0 gap.
    do_op(2'b11, 64'h7E, 1'b0, 1'b1);
    do_op(2'b01, 64'h00, 1'b1, 1'b1);
    chk8("cnt1", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(2'b01, 64'h00, 1'b1, 1'b1);
    chk8("cnt2", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    do_op(2'b01, 64'h00, 1'b1, 1'b0);
    chk8("cnt_gap", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(2'b01, 64'h00, 1'b1, 1'b1);
    chk8("cnt3", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("cnt3");

    // Hold keeps flags but still strobes VLD.
    do_op(2'b00, 64'h12, 1'b1, 1'b1);
    chk8("hold", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous clear between edges with an add pending.
    do_op(2'b11, 64'h55, 1'b0, 1'b1);
    check_all("ld_55");
    OP = 2'b01; b = 64'h01; CIN = 1'b1; SP = 1'b1;
    #2;
    CD = 1'b1;
    #1;
    model_reset();
    chk8("cd_async", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("cd_async");
    repeat (2) begin
      @(posedge CK);
      #1;
      check_all("cd_held");
    end
    CD = 1'b0;
    do_op(2'b01, 64'h03, 1'b0, 1'b1);
    chk8("after_cd", 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("after_cd");

    // Random regression across all widths.
    for (int n = 0; n < 10000; n++) begin
      logic [1:0]  rop;
      logic [63:0] rb;
      logic        rcin, rsp;
      rop  = 2'($urandom_range(0, 3));
      rb   = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rb = (rb[0]) ? 64'd0 : {64{1'b1}};
      rcin = 1'($urandom_range(0, 1));
      rsp  = ($urandom_range(0, 4) != 0);
      do_op(rop, rb, rcin, rsp);
      check_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
